mac_dot_seq: RTL and testbench

- Upstream sequencer for the packed-INT8 MAC/ReLU stage.
- Accepts a dot-product job (operand base addresses, length in 32-bit words) and streams word pairs from two synchronous-read operand SRAMs into the MAC.
- Clears the MAC accumulator before the first word, then asserts accumulate for each word pair.
- Captures the MAC's combinational ReLU result on the last word and returns it through a valid/ready result port to the custom-instruction writeback.

---
 rtl/mac_dot_seq_pkg.sv | 21 ++
 rtl/mac_dot_seq_addr_gen.sv | 69 ++++++
 rtl/mac_dot_seq.sv | 187 ++++++++++++++++++
 tb/tb_mac_dot_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_dot_seq_pkg.sv
// mac_dot_seq_pkg
//   Shared types and constants for the packed-INT8 dot-product sequencer.
//   - state_t      : sequencer FSM state encoding (IDLE, CLR, RUN, DONE)
//   - DEF_ADDR_W   : default operand SRAM word-address width
//   - DEF_LEN_W    : default job length width
//   - WORD_W       : operand / result word width

package mac_dot_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_seq_addr_gen.sv
// mac_dot_seq_addr_gen
//   Operand address generator: two wrapping word-address counters (A and B)
//   plus the remaining-length counter of the current job.
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     load_i             load bases and length (job accepted)
//     step_i             one read issued: advance both addresses, count down
//     len_i              job length in word pairs
//     base_a_i/base_b_i  first word address of each operand
//     addr_a_o/addr_b_o  address of the next read to issue
//     last_o             no reads left to issue (remaining == 0)

module mac_dot_seq_addr_gen
    import mac_dot_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    always_comb begin
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        rem_d    = rem_q;
        if (load_i) begin
            addr_a_d = base_a_i;
            addr_b_d = base_b_i;
            rem_d    = len_i;
        end else if (step_i && (rem_q != '0)) begin
            // Addresses wrap naturally at 2^ADDR_W; the length counter is
            // guarded so it can never wrap below zero.
            addr_a_d = addr_a_q + 1'b1;
            addr_b_d = addr_b_q + 1'b1;
            rem_d    = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            rem_q    <= '0;
        end else begin
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            rem_q    <= rem_d;
        end
    end

    assign addr_a_o = addr_a_q;
    assign addr_b_o = addr_b_q;
    assign last_o   = (rem_q == '0);

endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq
//   Sequencer in front of the packed-INT8 MAC/ReLU stage. Takes a dot-product
//   job, streams word pairs from two synchronous-read SRAMs into the MAC
//   (clear first, then one accumulate per pair) and returns the MAC's ReLU
//   result on a valid/ready port.
//
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     start_valid/start_ready        job request handshake
//     start_len/base_a/base_b        job length (word pairs) and base addresses
//     mem_{a,b}_re/addr/rdata        operand SRAM read ports (1-cycle latency)
//     mac_clr_acc, mac_en            MAC control
//     mac_rs1, mac_rs2               MAC operands (zero when mac_en is low)
//     mac_rd                         MAC combinational ReLU(next accumulator)
//     res_valid/res_ready/res_data   result handshake and registered result
//     busy                           high outside IDLE
//     dbg_state                      current FSM state (state_t encoding)
//     perf_jobs, perf_busy_cycles    saturating counters, only when the
//                                    macro MAC_DOT_SEQ_PERF_EN is defined
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. start_ready is high only in IDLE; res_valid stays high with
//   res_data stable until res_ready is seen, and drops on the following cycle.

module mac_dot_seq
    import mac_dot_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [ADDR_W-1:0] start_base_a,
    input  logic [ADDR_W-1:0] start_base_b,
    output logic              mem_a_re,
    output logic [ADDR_W-1:0] mem_a_addr,
    input  logic [WORD_W-1:0] mem_a_rdata,
    output logic              mem_b_re,
    output logic [ADDR_W-1:0] mem_b_addr,
    input  logic [WORD_W-1:0] mem_b_rdata,
    output logic              mac_clr_acc,
    output logic              mac_en,
    output logic [WORD_W-1:0] mac_rs1,
    output logic [WORD_W-1:0] mac_rs2,
    input  logic [WORD_W-1:0] mac_rd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              busy,
    output logic [1:0]        dbg_state
`ifdef MAC_DOT_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_jobs,
    output logic [31:0]       perf_busy_cycles
`endif
);

    state_t            state_q;
    logic              start_ready_q;
    logic              busy_q;
    logic              clr_q;
    logic              en_q;
    logic              res_valid_q;
    logic [WORD_W-1:0] res_data_q;

    logic              ag_load;
    logic              ag_step;
    logic              ag_last;

    // A read is issued in CLR and RUN whenever words remain; the same pulse
    // advances the address/length counters.
    assign ag_load = (state_q == ST_IDLE) && start_valid;
    assign ag_step = ((state_q == ST_CLR) || (state_q == ST_RUN)) && !ag_last;

    mac_dot_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ag_load),
        .step_i   (ag_step),
        .len_i    (start_len),
        .base_a_i (start_base_a),
        .base_b_i (start_base_b),
        .addr_a_o (mem_a_addr),
        .addr_b_o (mem_b_addr),
        .last_o   (ag_last)
    );

    // Control flags are registered alongside the state so each one is a
    // clean flop output. In RUN, ag_last means no read was issued this cycle,
    // so the pair on the MAC now is the final one and mac_rd is the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            clr_q         <= 1'b0;
            en_q          <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        state_q       <= ST_CLR;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        clr_q         <= 1'b1;
                    end
                end
                ST_CLR: begin
                    clr_q <= 1'b0;
                    if (ag_last) begin
                        // Zero-length job: nothing to accumulate.
                        res_data_q  <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        en_q    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ag_last) begin
                        res_data_q  <= mac_rd;
                        en_q        <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign mac_clr_acc = clr_q;
    assign mac_en      = en_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign mem_a_re    = ag_step;
    assign mem_b_re    = ag_step;
    assign dbg_state   = state_q;

    // Operands are gated so the MAC sees zeros whenever it is not enabled.
    assign mac_rs1 = en_q ? mem_a_rdata : '0;
    assign mac_rs2 = en_q ? mem_b_rdata : '0;

`ifdef MAC_DOT_SEQ_PERF_EN
    logic [31:0] perf_jobs_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_jobs_q <= '0;
            perf_busy_q <= '0;
        end else begin
            if (res_valid_q && res_ready && (perf_jobs_q != '1)) begin
                perf_jobs_q <= perf_jobs_q + 1'b1;
            end
            if (busy_q && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 1'b1;
            end
        end
    end

    assign perf_jobs        = perf_jobs_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq
//   Directed bench for mac_dot_seq with ADDR_W=4 so address wrap is reachable.
//   Surrounds the DUT with two synchronous-read SRAM models and a packed-INT8
//   MAC model (four signed byte lanes, ReLU of the next accumulator).

module tb_mac_dot_seq;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              start_valid;
    logic              start_ready;
    logic [LEN_W-1:0]  start_len;
    logic [ADDR_W-1:0] start_base_a;
    logic [ADDR_W-1:0] start_base_b;
    logic              mem_a_re;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [31:0]       mem_a_rdata = '0;
    logic              mem_b_re;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [31:0]       mem_b_rdata = '0;
    logic              mac_clr_acc;
    logic              mac_en;
    logic [31:0]       mac_rs1;
    logic [31:0]       mac_rs2;
    logic [31:0]       mac_rd;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef MAC_DOT_SEQ_PERF_EN
    logic [31:0]       perf_jobs;
    logic [31:0]       perf_busy_cycles;
`endif

    mac_dot_seq #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_len    (start_len),
        .start_base_a (start_base_a),
        .start_base_b (start_base_b),
        .mem_a_re     (mem_a_re),
        .mem_a_addr   (mem_a_addr),
        .mem_a_rdata  (mem_a_rdata),
        .mem_b_re     (mem_b_re),
        .mem_b_addr   (mem_b_addr),
        .mem_b_rdata  (mem_b_rdata),
        .mac_clr_acc  (mac_clr_acc),
        .mac_en       (mac_en),
        .mac_rs1      (mac_rs1),
        .mac_rs2      (mac_rs2),
        .mac_rd       (mac_rd),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .dbg_state    (dbg_state)
`ifdef MAC_DOT_SEQ_PERF_EN
        ,
        .perf_jobs        (perf_jobs),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    // ---------------- SRAM models ----------------
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];

    always @(posedge clk) begin
        if (mem_a_re) mem_a_rdata <= mem_a[mem_a_addr];
        if (mem_b_re) mem_b_rdata <= mem_b[mem_b_addr];
    end

    // ---------------- MAC model ----------------
    logic signed [31:0] acc = '0;
    logic signed [31:0] dot;
    logic signed [31:0] acc_nx;

    always_comb begin
        dot = '0;
        for (int i = 0; i < 4; i++) begin
            dot = dot + 32'($signed(mac_rs1[8*i +: 8])) * 32'($signed(mac_rs2[8*i +: 8]));
        end
        acc_nx = mac_clr_acc ? 32'sd0 : (mac_en ? acc + dot : acc);
        mac_rd = acc_nx[31] ? 32'd0 : acc_nx;
    end

    always @(posedge clk) acc <= acc_nx;

    // ---------------- scoreboard / bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    int          lat;
    int          en_cnt;
    int          clr_cnt;
    int          both_cnt;
    int          clr_cyc;
    int          first_en;
    logic [31:0] en_rs1;
    logic [31:0] en_rs2;
    logic [ADDR_W-1:0] rd_a[$];
    logic [ADDR_W-1:0] rd_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents a job for one edge (cycle T), then watches cycles T+1, T+2, ...
    // at the falling edge until res_valid, bounded by a cycle budget.
    task automatic run_job(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] ba,
                           input logic [ADDR_W-1:0] bb);
        @(negedge clk);
        start_len    = len;
        start_base_a = ba;
        start_base_b = bb;
        start_valid  = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        lat = -1; en_cnt = 0; clr_cnt = 0; both_cnt = 0; clr_cyc = 0; first_en = 0;
        en_rs1 = '0; en_rs2 = '0;
        rd_a.delete();
        rd_b.delete();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (mac_clr_acc) begin clr_cnt++; clr_cyc = k; end
            if (mac_en) begin
                en_cnt++;
                if (first_en == 0) first_en = k;
                en_rs1 = mac_rs1;
                en_rs2 = mac_rs2;
            end
            if (mac_en && mac_clr_acc) both_cnt++;
            if (mem_a_re) rd_a.push_back(mem_a_addr);
            if (mem_b_re) rd_b.push_back(mem_b_addr);
            if (res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, res_valid, 1'b0);
        check({tag, "_start_ready"}, start_ready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start_valid = 1'b0; start_len = '0;
        start_base_a = '0; start_base_b = '0; res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'h0102_0304;
            mem_b[i] = 32'h0101_0101;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_mac_en", mac_en, 1'b0);
        check("rst_clr", mac_clr_acc, 1'b0);
        check("rst_re_a", mem_a_re, 1'b0);
        check("rst_re_b", mem_b_re, 1'b0);
        rst = 1'b0;

        // len=1: 1+2+3+4 = 10, ready at T+3
        run_job(8'd1, 4'd0, 4'd0);
        check("t1_lat", lat, 32'd3);
        check("t1_res", res_data, 32'd10);
        check("t1_clr_cnt", clr_cnt, 32'd1);
        check("t1_clr_cyc", clr_cyc, 32'd1);
        check("t1_en_cnt", en_cnt, 32'd1);
        check("t1_first_en", first_en, 32'd2);
        check("t1_rs1", en_rs1, 32'h0102_0304);
        check("t1_rs2", en_rs2, 32'h0101_0101);
        check("t1_state_done", dbg_state, 2'd3);
        accept("t1");
        check("idle_rs1_zero", mac_rs1, 32'd0);
        check("idle_re_a", mem_a_re, 1'b0);

        // len=2 of all -1 lanes: raw -8, ReLU gives 0
        mem_a[4] = 32'hFFFF_FFFF;
        mem_a[5] = 32'hFFFF_FFFF;
        run_job(8'd2, 4'd4, 4'd4);
        check("neg_lat", lat, 32'd4);
        check("neg_en_cnt", en_cnt, 32'd2);
        check("neg_res", res_data, 32'd0);
        accept("neg");

        // len=3: three consecutive accumulates, 30 at T+5
        run_job(8'd3, 4'd0, 4'd0);
        check("t3_lat", lat, 32'd5);
        check("t3_en_cnt", en_cnt, 32'd3);
        check("t3_first_en", first_en, 32'd2);
        check("t3_res", res_data, 32'd30);
        check("t3_overlap", both_cnt, 32'd0);
        accept("t3");

        // len=0: no reads, no accumulate, result 0 at T+2
        run_job(8'd0, 4'd0, 4'd0);
        check("z_lat", lat, 32'd2);
        check("z_res", res_data, 32'd0);
        check("z_reads", rd_a.size(), 32'd0);
        check("z_en_cnt", en_cnt, 32'd0);
        check("z_clr_cnt", clr_cnt, 32'd1);
        accept("z");

        // address wrap: A 15,0,1  B 14,15,0
        run_job(8'd3, 4'd15, 4'd14);
        check("w_lat", lat, 32'd5);
        check("w_res", res_data, 32'd30);
        check("w_na", rd_a.size(), 32'd3);
        check("w_nb", rd_b.size(), 32'd3);
        if (rd_a.size() == 3 && rd_b.size() == 3) begin
            check("w_a0", rd_a[0], 4'd15);
            check("w_a1", rd_a[1], 4'd0);
            check("w_a2", rd_a[2], 4'd1);
            check("w_b0", rd_b[0], 4'd14);
            check("w_b1", rd_b[1], 4'd15);
            check("w_b2", rd_b[2], 4'd0);
        end
        accept("w");

        // backpressure: 2*3 per lane, 4 lanes = 24; stray start ignored
        mem_a[2] = 32'h0202_0202;
        mem_b[2] = 32'h0303_0303;
        run_job(8'd1, 4'd2, 4'd2);
        check("bp_lat", lat, 32'd3);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                start_len = 8'd5; start_base_a = 4'd0; start_base_b = 4'd0;
                start_valid = 1'b1;
            end
            if (c == 3) start_valid = 1'b0;
            @(negedge clk);
            check("bp_valid", res_valid, 1'b1);
            check("bp_data", res_data, 32'h18);
            check("bp_state", dbg_state, 2'd3);
        end
        check("bp_start_ready", start_ready, 1'b0);
        accept("bp");
        @(negedge clk);
        check("bp_no_job", busy, 1'b0);

        // reset in the middle of RUN
        start_len = 8'd5; start_base_a = 4'd0; start_base_b = 4'd0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_in_run", mac_en, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_start_ready", start_ready, 1'b1);
        check("rr_busy", busy, 1'b0);
        check("rr_mac_en", mac_en, 1'b0);
        check("rr_clr", mac_clr_acc, 1'b0);
        check("rr_re_a", mem_a_re, 1'b0);
        check("rr_re_b", mem_b_re, 1'b0);
        check("rr_addr_a", mem_a_addr, 4'd0);
        check("rr_res_valid", res_valid, 1'b0);
        check("rr_res_data", res_data, 32'd0);
        check("rr_rs1", mac_rs1, 32'd0);
        check("rr_state", dbg_state, 2'd0);
        rst = 1'b0;

        run_job(8'd1, 4'd0, 4'd0);
        check("post_rst_lat", lat, 32'd3);
        check("post_rst_res", res_data, 32'd10);
        accept("post_rst");

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
